// File: rtl/operand_pkg.sv
// Shared definitions for the B-operand select pipeline: source tags and the
// constant-unit extension helper.
package operand_pkg;

    // Upper bound on operand width supported by extend_const.
    localparam int MAX_W = 64;

    localparam int SRC_REG      = 0;
    localparam int SRC_CONST    = 1;
    localparam int SRC_FWD_BASE = 2;

    // Extends the low raw_w bits of raw to MAX_W bits. Callers truncate the
    // result to their own operand width.
    function automatic logic [MAX_W-1:0] extend_const(
        input logic [MAX_W-1:0] raw,
        input int               raw_w,
        input logic             sext
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb_shift;
        logic             fill;
        mask      = (MAX_W'(1) << raw_w) - MAX_W'(1);
        msb_shift = raw >> (raw_w - 1);
        fill      = sext & msb_shift[0];
        return (raw & mask) | ({MAX_W{fill}} & ~mask);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: picks the lowest-index valid forwarding source whose
// destination address equals the B read address.
module fwd_match #(
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 3,
    parameter int ZERO_REG   = 1,
    parameter int IDX_W      = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1
) (
    input  logic [REG_ADDR_W-1:0]         b_addr,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    output logic                          hit,
    output logic [IDX_W-1:0]              idx
);

    logic zero_blocked;

    assign zero_blocked = (ZERO_REG != 0) && (b_addr == '0);

    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk from the oldest source down so the youngest match wins last.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == b_addr)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
        if (zero_blocked) begin
            hit = 1'b0;
            idx = '0;
        end
    end

endmodule

// File: rtl/operand_b_select_pipe.sv
// ALU B-operand select (register / constant / forward) with a valid-ready
// output register and a saturating forwarding-event counter.
module operand_b_select_pipe
    import operand_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CONST_W    = 6,
    parameter int REG_ADDR_W = 3,
    parameter int NUM_FWD    = 2,
    parameter int ZERO_REG   = 1,
    parameter int SRC_W      = $clog2(NUM_FWD + 2)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              b_data,
    input  logic [REG_ADDR_W-1:0]         b_addr,
    input  logic [CONST_W-1:0]            const_in,
    input  logic                          const_sext,
    input  logic                          mb,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*WIDTH-1:0]      fwd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              bus_b,
    output logic [SRC_W-1:0]              bus_b_src,
    output logic [15:0]                   fwd_count
);

    localparam int IDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

    logic              accept;
    logic              fwd_hit;
    logic [IDX_W-1:0]  fwd_idx;
    logic [WIDTH-1:0]  fwd_sel;
    logic [WIDTH-1:0]  sel_data;
    logic [SRC_W-1:0]  sel_src;
    logic              sel_is_fwd;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  bus_b_q,     bus_b_d;
    logic [SRC_W-1:0]  src_q,       src_d;
    logic [15:0]       fwd_count_q, fwd_count_d;

    fwd_match #(
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG),
        .IDX_W      (IDX_W)
    ) u_fwd_match (
        .b_addr    (b_addr),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .hit       (fwd_hit),
        .idx       (fwd_idx)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fwd_idx == IDX_W'(i)) begin
                fwd_sel = fwd_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Constant wins over forwarding; forwarding wins over the register file.
    always_comb begin
        sel_data   = b_data;
        sel_src    = SRC_W'(SRC_REG);
        sel_is_fwd = 1'b0;
        if (mb) begin
            sel_data = WIDTH'(extend_const(MAX_W'(const_in), CONST_W, const_sext));
            sel_src  = SRC_W'(SRC_CONST);
        end else if (fwd_hit) begin
            sel_data   = fwd_sel;
            sel_src    = SRC_W'(SRC_FWD_BASE) + SRC_W'(fwd_idx);
            sel_is_fwd = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bus_b_d     = bus_b_q;
        src_d       = src_q;
        fwd_count_d = fwd_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            bus_b_d     = sel_data;
            src_d       = sel_src;
            if (sel_is_fwd && (fwd_count_q != 16'hFFFF)) begin
                fwd_count_d = fwd_count_q + 16'd1;
            end
        end else if (out_ready) begin
            // Operand consumed with nothing new behind it; data is kept.
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bus_b_q     <= '0;
            src_q       <= '0;
            fwd_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bus_b_q     <= bus_b_d;
            src_q       <= src_d;
            fwd_count_q <= fwd_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bus_b     = bus_b_q;
    assign bus_b_src = src_q;
    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_operand_b_select_pipe.sv
// Self-checking bench for operand_b_select_pipe: directed corner cases plus
// randomized traffic against a transaction-level reference model.
module tb_operand_b_select_pipe;

    localparam int WIDTH      = 16;
    localparam int CONST_W    = 6;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_FWD    = 2;
    localparam int SRC_W      = 2;

    logic                          clk;
    logic                          reset;
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              b_data;
    logic [REG_ADDR_W-1:0]         b_addr;
    logic [CONST_W-1:0]            const_in;
    logic                          const_sext;
    logic                          mb;
    logic [NUM_FWD-1:0]            fwd_valid;
    logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr;
    logic [NUM_FWD*WIDTH-1:0]      fwd_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              bus_b;
    logic [SRC_W-1:0]              bus_b_src;
    logic [15:0]                   fwd_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid;
    logic [15:0] m_bus;
    logic [1:0]  m_src;
    int          m_cnt;
    logic [15:0] consumed[$];

    operand_b_select_pipe #(
        .WIDTH      (WIDTH),
        .CONST_W    (CONST_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD),
        .ZERO_REG   (1),
        .SRC_W      (SRC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .b_data     (b_data),
        .b_addr     (b_addr),
        .const_in   (const_in),
        .const_sext (const_sext),
        .mb         (mb),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bus_b      (bus_b),
        .bus_b_src  (bus_b_src),
        .fwd_count  (fwd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected operand for the current inputs, from the selection rules.
    task automatic model_select(output logic [15:0] d, output logic [1:0] s, output bit used_fwd);
        int c;
        bit found;
        used_fwd = 0;
        found    = 0;
        if (mb) begin
            c = int'(const_in);
            if (const_sext && c >= 32) c = c + 65536 - 64;
            d = 16'(c);
            s = 2'd1;
        end else begin
            d = b_data;
            s = 2'd0;
            if (b_addr != 0) begin
                for (int i = 0; i < NUM_FWD; i++) begin
                    if (!found && fwd_valid[i] && fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == b_addr) begin
                        found = 1;
                        d = fwd_data[i*WIDTH +: WIDTH];
                        s = 2'(2 + i);
                    end
                end
            end
            used_fwd = found;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic do_cycle(output bit accepted);
        bit          exp_ready;
        logic [15:0] d;
        logic [1:0]  s;
        bit          uf;
        #1;
        exp_ready = !m_valid || out_ready;
        check("in_ready", in_ready, exp_ready);
        accepted = in_valid && exp_ready;
        model_select(d, s, uf);
        if (m_valid && out_ready) consumed.push_back(m_bus);
        @(posedge clk);
        #1;
        if (accepted) begin
            m_valid = 1;
            m_bus   = d;
            m_src   = s;
            if (uf && m_cnt < 65535) m_cnt++;
        end else if (out_ready) begin
            m_valid = 0;
        end
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("bus_b", bus_b, m_bus);
            check("bus_b_src", bus_b_src, m_src);
        end
        check("fwd_count", fwd_count, m_cnt);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_bus   = '0;
        m_src   = '0;
        m_cnt   = 0;
    endtask

    initial begin
        bit acc;
        int cyc;
        int tries;
        bit pat[4];

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        b_data     = '0;
        b_addr     = '0;
        const_in   = '0;
        const_sext = 1'b0;
        mb         = 1'b0;
        fwd_valid  = '0;
        fwd_addr   = '0;
        fwd_data   = '0;
        model_reset();

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_bus_b", bus_b, 0);
        check("rst_src", bus_b_src, 0);
        check("rst_fwd_count", fwd_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Constant extension
        in_valid = 1; out_ready = 1; mb = 1; const_in = 6'b100101; const_sext = 1;
        do_cycle(acc);
        check("const_sext_val", bus_b, 16'hFFE5);
        check("const_sext_src", bus_b_src, 1);
        const_sext = 0;
        do_cycle(acc);
        check("const_zext_val", bus_b, 16'h0025);
        check("const_zext_src", bus_b_src, 1);

        // Forward priority; forwards ignored under mb
        mb = 1; fwd_valid = 2'b11; b_addr = 3; fwd_addr = {3'd3, 3'd3};
        fwd_data = {16'h2222, 16'h1111};
        do_cycle(acc);
        check("const_ignores_fwd_cnt", fwd_count, 0);
        mb = 0;
        do_cycle(acc);
        check("fwd_prio_val", bus_b, 16'h1111);
        check("fwd_prio_src", bus_b_src, 2);
        check("fwd_prio_cnt", fwd_count, 1);
        fwd_valid = 2'b10;
        do_cycle(acc);
        check("fwd1_val", bus_b, 16'h2222);
        check("fwd1_src", bus_b_src, 3);
        check("fwd1_cnt", fwd_count, 2);

        // Zero register is never forwarded
        b_addr = 0; fwd_valid = 2'b01; fwd_addr = '0; b_data = 16'h0000;
        fwd_data = {16'h2222, 16'hBEEF};
        do_cycle(acc);
        check("zero_reg_val", bus_b, 16'h0000);
        check("zero_reg_src", bus_b_src, 0);
        check("zero_reg_cnt", fwd_count, 2);

        // Back-pressure stream
        in_valid = 0; fwd_valid = 0; b_addr = 1;
        do_cycle(acc);
        consumed.delete();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            b_data   = 16'hA001 + 16'(k);
            in_valid = 1;
            tries    = 0;
            acc      = 0;
            while (!acc && tries < 8) begin
                out_ready = (cyc < 4) ? pat[cyc] : 1'b1;
                do_cycle(acc);
                cyc++;
                tries++;
            end
            if (!acc) check("bp_accept_timeout", 0, 1);
        end
        in_valid = 0; out_ready = 1;
        do_cycle(acc);
        do_cycle(acc);
        check("bp_count", consumed.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < consumed.size()) check("bp_order", consumed[k], 16'hA001 + 16'(k));
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(3) != 0);
            mb         = ($urandom_range(3) == 0);
            const_in   = CONST_W'($urandom);
            const_sext = 1'($urandom);
            b_addr     = REG_ADDR_W'($urandom);
            b_data     = WIDTH'($urandom);
            fwd_valid  = NUM_FWD'($urandom);
            for (int i = 0; i < NUM_FWD; i++) begin
                fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] = $urandom_range(1) ? b_addr : REG_ADDR_W'($urandom);
                fwd_data[i*WIDTH +: WIDTH]           = WIDTH'($urandom);
            end
            do_cycle(acc);
        end

        // Reset asserted while an operand is stalled
        mb = 0; in_valid = 1; out_ready = 1; b_addr = 2; fwd_valid = 2'b01;
        fwd_addr = {3'd0, 3'd2}; fwd_data = {16'h0000, 16'h5A5A};
        do_cycle(acc);
        in_valid = 0; out_ready = 0;
        do_cycle(acc);
        check("stall_hold_val", bus_b, 16'h5A5A);
        reset = 1'b1;
        #2;
        check("midstall_rst_valid", out_valid, 0);
        check("midstall_rst_bus_b", bus_b, 0);
        check("midstall_rst_src", bus_b_src, 0);
        check("midstall_rst_cnt", fwd_count, 0);
        model_reset();
        reset = 1'b0;
        @(negedge clk);

        // Counter saturation
        consumed.delete();
        in_valid = 1; out_ready = 1; mb = 0; b_addr = 5; fwd_valid = 2'b01;
        fwd_addr = {3'd1, 3'd5};
        for (int n = 0; n < 65534; n++) begin
            fwd_data[WIDTH-1:0] = WIDTH'(n);
            do_cycle(acc);
            if (n % 4096 == 0) consumed.delete();
        end
        check("sat_pre", fwd_count, 16'hFFFE);
        do_cycle(acc);
        check("sat_reach", fwd_count, 16'hFFFF);
        do_cycle(acc);
        check("sat_hold1", fwd_count, 16'hFFFF);
        do_cycle(acc);
        check("sat_hold2", fwd_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_b_select_pipe.md
Name: operand_b_select_pipe

Overview:
Parametrised successor to the B-operand multiplexer. Selects the ALU B operand from register-file data, an extended instruction constant, or one of NUM_FWD forwarding paths, then holds it in a valid/ready pipeline register feeding Bus_B. It sits between the decode/register-read stage and the execute stage, and adds operand forwarding, constant sign/zero extension, stall handling and a forwarding-event counter.

Parameters:
WIDTH, 16, operand/bus width in bits
CONST_W, 6, constant-unit field width; must be < WIDTH
REG_ADDR_W, 3, register address width
NUM_FWD, 2, number of forwarding sources; index 0 is highest priority (youngest stage)
ZERO_REG, 1, 1 = register address 0 is never forwarded (always uses b_data)
SRC_W, $clog2(NUM_FWD+2), width of the source tag

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream operand request valid
in_ready  out  1  block can accept a request this cycle
b_data  in  WIDTH  register-file B read data
b_addr  in  REG_ADDR_W  register address of b_data
const_in  in  CONST_W  constant-unit field
const_sext  in  1  1 = sign-extend const_in, 0 = zero-extend
mb  in  1  1 = select constant, 0 = register/forwarded value
fwd_valid  in  NUM_FWD  per-source forward valid
fwd_addr  in  NUM_FWD*REG_ADDR_W  packed destination addresses; source i is in slice [i*REG_ADDR_W +: REG_ADDR_W]
fwd_data  in  NUM_FWD*WIDTH  packed forward data; source i is in slice [i*WIDTH +: WIDTH]
out_valid  out  1  bus_b holds a valid operand
out_ready  in  1  execute stage consumes the operand
bus_b  out  WIDTH  registered selected operand
bus_b_src  out  SRC_W  tag: 0 = register, 1 = constant, 2+i = forward source i
fwd_count  out  16  saturating count of accepted requests that used a forward

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, bus_b=0, bus_b_src=0, fwd_count=0. Any held operand is discarded. The block accepts input again on the first clock edge after reset deasserts.
- in_ready = !out_valid || out_ready. This is combinational and permits full throughput.
- Accept = in_valid && in_ready. On accept, the next edge loads bus_b/bus_b_src and sets out_valid=1. Input-to-output latency is 1 cycle.
- If out_valid && out_ready && !accept, the next edge clears out_valid. bus_b keeps its last value.
- If out_valid && !out_ready (stall), bus_b, bus_b_src and out_valid hold unchanged. in_ready=0.
- Selection priority, evaluated at accept:
  1. mb=1 selects the constant. Zero extension: upper WIDTH-CONST_W bits = 0. Sign extension: upper bits = const_in[CONST_W-1]. Forwarding is ignored.
  2. Otherwise, take the lowest index i with fwd_valid[i] && fwd_addr[i]==b_addr, giving bus_b = fwd_data[i] and src = 2+i. When ZERO_REG=1 and b_addr==0, this step is skipped.
  3. Otherwise, bus_b = b_data and src = 0.
- fwd_count increments by 1 on each accept that takes case 2, and saturates at 16'hFFFF. It is not affected by stalls.
- Multiple matching forwards: only the highest-priority (lowest-index) match is used.
- Inputs are sampled only at accept; changes during a stall have no effect on the held operand.

Decomposition:
- Shared package operand_pkg: source tag constants SRC_REG=0, SRC_CONST=1, SRC_FWD_BASE=2; function for constant extension (const_in, sext) -> WIDTH.
- Sub-module fwd_match: combinational priority matcher. Inputs: b_addr, fwd_valid, fwd_addr. Outputs: hit, one-hot/index of the winning source. Parametrised by NUM_FWD, REG_ADDR_W, ZERO_REG.
- The top level contains the select mux, pipeline register, handshake and counter.

Test Plan:
- Reset mid-stall: load an operand, hold out_ready=0, assert reset -> out_valid=0, bus_b=0, fwd_count=0 immediately (asynchronous).
- Constant extension (WIDTH=16, CONST_W=6), mb=1, const_in=6'b100101: const_sext=1 -> bus_b=16'hFFE5, src=1; const_sext=0 -> bus_b=16'h0025, src=1.
- Forward priority: b_addr=3, fwd_valid=2'b11, both fwd_addr=3, fwd_data[0]=16'h1111, fwd_data[1]=16'h2222 -> bus_b=16'h1111, src=2, fwd_count+1. With fwd_valid=2'b10 -> bus_b=16'h2222, src=3.
- Zero register: b_addr=0, fwd_valid=2'b01, fwd_addr[0]=0, b_data=16'h0000, fwd_data[0]=16'hBEEF -> bus_b=16'h0000, src=0, fwd_count unchanged.
- Back-pressure: stream 4 requests (b_data=16'hA001..A004) with out_ready toggling 1,0,1,1 -> in_ready=0 exactly during the stall cycle, no operand dropped or duplicated, outputs appear in order with 1-cycle latency when unstalled.
- Counter saturation: preload via 65535 forwarded accepts, then 2 more -> fwd_count stays 16'hFFFF.
